// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button debounce, STOP/RUN/CLEAR/LAP sequencing,
// tick enable, counter clear and live/lap display mux.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNT_W         = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_btn_run,
    input  logic               i_btn_clear,
    input  logic               i_btn_lap,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_run_en,
    output logic               o_clear,
    output logic [COUNT_W-1:0] o_disp,
    output logic               o_lap_active,
    output logic [2:0]         o_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order of every button vector: [0]=run, [1]=clear, [2]=lap
    localparam int B_RUN   = 0;
    localparam int B_CLEAR = 1;
    localparam int B_LAP   = 2;

    typedef enum logic [2:0] {
        ST_STOP  = 3'b000,
        ST_RUN   = 3'b001,
        ST_CLEAR = 3'b010,
        ST_LAP   = 3'b011
    } state_t;

    logic [2:0]         btn_raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         db;
    logic [2:0]         db_prev;
    logic [2:0]         press;
    logic [CNT_W-1:0]   cnt [3];

    state_t             state_q;
    state_t             state_d;
    logic               lap_load;
    logic [COUNT_W-1:0] lap_reg;

    assign btn_raw = {i_btn_lap, i_btn_clear, i_btn_run};

    // Synchronize, debounce and edge-detect all three buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            press   <= '0;
            for (int b = 0; b < 3; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db;
            press   <= db & ~db_prev;
            for (int b = 0; b < 3; b++) begin
                if (sync2[b] != db[b]) begin
                    if (cnt[b] == CNT_MAX) begin
                        db[b]  <= sync2[b];
                        cnt[b] <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + CNT_W'(1);
                    end
                end else begin
                    cnt[b] <= '0;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Lap snapshot, captured on the RUN->LAP edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_reg <= '0;
        end else if (lap_load) begin
            lap_reg <= i_count;
        end
    end

    // Next state with run > clear > lap priority, plus Moore outputs
    always_comb begin
        state_d      = state_q;
        lap_load     = 1'b0;
        o_run_en     = 1'b0;
        o_clear      = 1'b0;
        o_lap_active = 1'b0;
        o_disp       = i_count;
        o_state      = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (press[B_RUN]) begin
                    state_d = ST_RUN;
                end else if (press[B_CLEAR]) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                o_run_en = 1'b1;
                if (press[B_RUN]) begin
                    state_d = ST_STOP;
                end else if (press[B_LAP]) begin
                    state_d  = ST_LAP;
                    lap_load = 1'b1;
                end
            end
            ST_CLEAR: begin
                o_clear = 1'b1;
                state_d = ST_STOP;
            end
            ST_LAP: begin
                o_run_en     = 1'b1;
                o_lap_active = 1'b1;
                o_disp       = lap_reg;
                if (press[B_RUN]) begin
                    state_d = ST_STOP;
                end else if (press[B_LAP]) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4.
// Stimulus queues timed expectations; a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

    localparam int D  = 4;
    localparam int CW = 14;

    // Signal selectors for scoreboard entries
    localparam int S_STATE = 0;
    localparam int S_RUN   = 1;
    localparam int S_CLR   = 2;
    localparam int S_DISP  = 3;
    localparam int S_LAP   = 4;

    typedef struct packed {
        int cyc;
        int sig;
        int val;
        int tag;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          i_btn_run;
    logic          i_btn_clear;
    logic          i_btn_lap;
    logic [CW-1:0] i_count;
    logic          o_run_en;
    logic          o_clear;
    logic [CW-1:0] o_disp;
    logic          o_lap_active;
    logic [2:0]    o_state;

    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_lap   (i_btn_lap),
        .i_count     (i_count),
        .o_run_en    (o_run_en),
        .o_clear     (o_clear),
        .o_disp      (o_disp),
        .o_lap_active(o_lap_active),
        .o_state     (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dut_val(int sig);
        case (sig)
            S_STATE: return int'(o_state);
            S_RUN:   return int'(o_run_en);
            S_CLR:   return int'(o_clear);
            S_DISP:  return int'(o_disp);
            default: return int'(o_lap_active);
        endcase
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            S_STATE: return "o_state";
            S_RUN:   return "o_run_en";
            S_CLR:   return "o_clear";
            S_DISP:  return "o_disp";
            default: return "o_lap_active";
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (dut_val(sb[i].sig) != sb[i].val) begin
                    failures++;
                    $display("FAIL t%0d %s cyc=%0d got=%0d exp=%0d",
                             sb[i].tag, sig_name(sb[i].sig), cyc,
                             dut_val(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL t%0d %s missed cyc=%0d got=none exp=%0d",
                         sb[i].tag, sig_name(sb[i].sig), sb[i].cyc,
                         sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int ofs, int sig, int val, int tag);
        exp_t e;
        e.cyc = cyc + ofs;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0:       i_btn_run   = v;
            1:       i_btn_clear = v;
            default: i_btn_lap   = v;
        endcase
    endtask

    // Hold a button long enough to debounce, release, let it settle
    task automatic press_btn(int b);
        set_btn(b, 1'b1);
        step(10);
        set_btn(b, 1'b0);
        step(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        i_btn_lap   = 1'b0;
        i_count     = 14'd77;

        // Reset state
        step(3);
        expect_at(0, S_STATE, 0, 0);
        expect_at(0, S_RUN, 0, 0);
        expect_at(0, S_CLR, 0, 0);
        expect_at(0, S_LAP, 0, 0);
        expect_at(0, S_DISP, 77, 0);
        step(1);
        reset = 1'b0;
        step(2);

        // T2: 3-cycle glitch on clear is rejected
        i_btn_clear = 1'b1;
        for (int i = 0; i < 14; i++) begin
            expect_at(i, S_STATE, 0, 2);
            expect_at(i, S_CLR, 0, 2);
        end
        step(3);
        i_btn_clear = 1'b0;
        step(12);

        // T3: clear gives a one-cycle CLEAR state and pulse
        expect_at(7, S_STATE, 0, 3);
        expect_at(8, S_STATE, 2, 3);
        expect_at(8, S_CLR, 1, 3);
        expect_at(9, S_STATE, 0, 3);
        expect_at(9, S_CLR, 0, 3);
        expect_at(10, S_CLR, 0, 3);
        press_btn(1);

        // T1: run press latency and single press while held
        i_count   = 14'd100;
        i_btn_run = 1'b1;
        expect_at(7, S_STATE, 0, 1);
        expect_at(7, S_RUN, 0, 1);
        expect_at(8, S_STATE, 1, 1);
        expect_at(8, S_RUN, 1, 1);
        expect_at(8, S_DISP, 100, 1);
        expect_at(19, S_STATE, 1, 1);
        expect_at(29, S_STATE, 1, 1);
        step(20);
        i_btn_run = 1'b0;
        step(12);

        // T4: lap freezes 1234 while the count ramps and wraps
        i_count   = 14'd1234;
        expect_at(7, S_STATE, 1, 4);
        expect_at(8, S_STATE, 3, 4);
        expect_at(8, S_DISP, 1234, 4);
        expect_at(8, S_LAP, 1, 4);
        expect_at(8, S_RUN, 1, 4);
        press_btn(2);
        for (int v = 1240; v <= 1300; v += 10) begin
            i_count = CW'(v);
            expect_at(0, S_DISP, 1234, 4);
            step(1);
        end
        i_count = 14'd9999;
        expect_at(0, S_DISP, 1234, 4);
        step(1);
        i_count = 14'd0;
        expect_at(0, S_DISP, 1234, 4);
        expect_at(0, S_STATE, 3, 4);
        expect_at(0, S_RUN, 1, 4);
        step(5);
        i_count = 14'd500;
        expect_at(7, S_STATE, 3, 4);
        expect_at(8, S_STATE, 1, 4);
        expect_at(8, S_DISP, 500, 4);
        expect_at(8, S_LAP, 0, 4);
        press_btn(2);
        i_count = 14'd777;
        expect_at(0, S_DISP, 777, 4);
        step(2);

        // T5a: run and clear on the same cycle in RUN -> STOP only
        i_btn_run   = 1'b1;
        i_btn_clear = 1'b1;
        expect_at(8, S_STATE, 0, 5);
        expect_at(8, S_CLR, 0, 5);
        expect_at(9, S_STATE, 0, 5);
        expect_at(9, S_CLR, 0, 5);
        expect_at(10, S_CLR, 0, 5);
        step(10);
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
        step(10);

        // T5b: enter LAP, then clear is ignored
        press_btn(0);
        i_count = 14'd4321;
        press_btn(2);
        i_count = 14'd55;
        expect_at(0, S_STATE, 3, 5);
        expect_at(0, S_DISP, 4321, 5);
        expect_at(8, S_STATE, 3, 5);
        expect_at(9, S_STATE, 3, 5);
        expect_at(9, S_CLR, 0, 5);
        press_btn(1);

        // T6: reset in LAP with lap held mid-debounce
        i_btn_lap = 1'b1;
        step(3);
        reset = 1'b1;
        expect_at(0, S_STATE, 0, 6);
        expect_at(0, S_RUN, 0, 6);
        expect_at(0, S_LAP, 0, 6);
        expect_at(0, S_DISP, 55, 6);
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            expect_at(i, S_STATE, 0, 6);
        end
        step(12);
        i_btn_lap = 1'b0;
        step(10);

        // Reach any late expectations, then report leftovers
        step(3);
        foreach (sb[i]) begin
            checks++;
            failures++;
            $display("FAIL t%0d %s pending cyc=%0d got=none exp=%0d",
                     sb[i].tag, sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode controller for the 100 Hz stopwatch datapath (tick generator, 0–9999 tick counter, 4-digit FND driver).
- Debounces three raw push-buttons: run/stop, clear, lap.
- Converts them to single-cycle press events and sequences the stopwatch through STOP/RUN/CLEAR/LAP.
- Drives the tick-generator enable and the counter clear.
- Muxes live count or frozen lap value to the FND controller.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz); legal range >= 2.
COUNT_W, 14, width of count and display buses.

Ports:
clk  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high reset.
i_btn_run  in  1  raw run/stop button, asynchronous, active-high.
i_btn_clear  in  1  raw clear button, asynchronous, active-high.
i_btn_lap  in  1  raw lap button, asynchronous, active-high.
i_count  in  COUNT_W  live value from the tick counter.
o_run_en  out  1  enable to the 100 Hz tick generator.
o_clear  out  1  synchronous clear to the tick counter, one-cycle pulse.
o_disp  out  COUNT_W  value to the FND controller.
o_lap_active  out  1  high while the display is frozen.
o_state  out  3  current FSM state encoding.

Behaviour:

Reset (async, active-high):
- state=STOP; lap_reg=0; all synchronizers, debounce counters, debounced levels and press pulses = 0.
- Outputs: o_run_en=0, o_clear=0, o_lap_active=0, o_state=3'b000, o_disp=i_count.

Per-button front end (three identical instances):
- 2-FF synchronizer producing s.
- Debounced level db:
  - if s != db, counter increments;
  - when counter == DEBOUNCE_CYCLES-1 and s != db still: db<=s, counter<=0;
  - any cycle with s == db: counter<=0.
- Counter width: $clog2(DEBOUNCE_CYCLES).
- press <= db & ~db_prev (registered), so press is exactly one cycle per 0->1 of db. Release generates no event.
- Latency: raw input first sampled high at edge k, held stable, gives db=1 at edge k+1+DEBOUNCE_CYCLES, press=1 at edge k+2+DEBOUNCE_CYCLES, FSM state change at edge k+3+DEBOUNCE_CYCLES.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored. Holding a button produces exactly one press.

FSM (encoding: STOP=000, RUN=001, CLEAR=010, LAP=011):
- Same-cycle press priority: run > clear > lap. Only the highest-priority legal event acts; the others are discarded, not queued.

| State | Event | Next state / action |
|---|---|---|
| STOP | run | RUN |
| STOP | clear | CLEAR |
| STOP | lap | ignored |
| RUN | run | STOP |
| RUN | lap | LAP; lap_reg <= i_count on the same edge |
| RUN | clear | ignored |
| LAP | lap | RUN (display returns to live) |
| LAP | run | STOP (display returns to live, lap_reg retained) |
| LAP | clear | ignored |
| CLEAR | (none) | one cycle, then unconditionally STOP |

- Press events arriving while in CLEAR are discarded.

Outputs (Moore, decoded combinationally from state):
- o_run_en = 1 in RUN and LAP.
- o_clear = 1 only in CLEAR, giving a 1-cycle pulse.
- o_lap_active = 1 only in LAP.
- o_disp = lap_reg in LAP, else i_count. Combinational mux with zero latency from i_count.
- o_state = state.

Counter wrap (9999 -> 0) is handled by the counter and needs no action here. In LAP, the frozen value is unaffected by wrap.

Reset mid-operation: immediate return to the reset values, including mid-debounce. A button still held when reset deasserts is treated as a fresh press after the full debounce latency.

Test Plan:
(All with DEBOUNCE_CYCLES=4.)
1. Reset, then raise i_btn_run at edge k and hold 20 cycles -> press on run at edge k+6; o_state=001 and o_run_en=1 from edge k+7; exactly one press while held.
2. 3-cycle glitch on i_btn_clear in STOP -> no press; o_state stays 000; o_clear never asserts.
3. In STOP, press clear -> o_state=010 and o_clear=1 for exactly 1 cycle, then o_state=000 and o_clear=0.
4. In RUN with i_count=1234, press lap -> o_state=011, o_disp=1234 while i_count ramps to 1300, o_run_en=1; press lap again -> o_state=001, o_disp tracks i_count; i_count wraps 9999->0 in LAP with o_disp frozen.
5. In RUN, press run and clear so both pulses land on the same cycle -> STOP taken, no CLEAR, o_clear=0. In LAP, press clear -> ignored, state stays 011.
6. Assert reset while in LAP with i_btn_lap held high -> o_state=000, o_run_en=0, o_lap_active=0 immediately; after release, a press is detected 6 cycles after the first sampled-high edge, but lap in STOP is ignored, so state stays 000.
